// File: rtl/accel_host_driver_if.sv
// rtl/accel_host_driver_if.sv - job/result streams and accelerator start/done wires
`ifndef FE_DATA_W
`define FE_DATA_W 32
`endif

interface accel_host_driver_if #(
    parameter int DATA_W = `FE_DATA_W
) ();
    logic              in_valid_i;
    logic              in_ready_o;
    logic [DATA_W-1:0] in_data_i;
    logic              res_valid_o;
    logic              res_ready_i;
    logic [DATA_W-1:0] res_data_o;
    logic              res_err_o;
    logic              acc_start_o;
    logic [DATA_W-1:0] acc_data_o;
    logic [DATA_W-1:0] acc_data_i;
    logic              acc_done_i;

    modport master (
        input  in_valid_i, in_data_i, res_ready_i, acc_data_i, acc_done_i,
        output in_ready_o, res_valid_o, res_data_o, res_err_o, acc_start_o, acc_data_o
    );

    modport slave (
        output in_valid_i, in_data_i, res_ready_i, acc_data_i, acc_done_i,
        input  in_ready_o, res_valid_o, res_data_o, res_err_o, acc_start_o, acc_data_o
    );
endinterface

// File: rtl/accel_host_driver.sv
// rtl/accel_host_driver.sv - start/done handshake initiator with bounded waits
`ifndef FE_DATA_W
`define FE_DATA_W 32
`endif

module accel_host_driver #(
    parameter int DATA_W         = `FE_DATA_W,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 16
) (
    input  logic                clk_i,
    input  logic                arst_n_i,
    accel_host_driver_if.master bus,
    output logic                busy_o,
    output logic [CNT_W-1:0]    job_count_o
);
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, REQ, REL, OUT} state_t;

    state_t            state;
    logic [TW-1:0]     timer;
    logic              acc_start;
    logic [DATA_W-1:0] acc_data;
    logic              res_valid;
    logic [DATA_W-1:0] res_data;
    logic              res_err;
    logic [CNT_W-1:0]  job_count;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state     <= IDLE;
            timer     <= '0;
            acc_start <= 1'b0;
            acc_data  <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_err   <= 1'b0;
            job_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid_i) begin
                        acc_data  <= bus.in_data_i;
                        acc_start <= 1'b1;
                        timer     <= '0;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    // done takes priority over an expiring timer on the same edge
                    if (bus.acc_done_i) begin
                        res_data  <= bus.acc_data_i;
                        res_err   <= 1'b0;
                        acc_start <= 1'b0;
                        timer     <= '0;
                        state     <= REL;
                    end else if (timer == TLIM) begin
                        res_data  <= '0;
                        res_err   <= 1'b1;
                        acc_start <= 1'b0;
                        timer     <= '0;
                        state     <= REL;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                REL: begin
                    if (!bus.acc_done_i) begin
                        res_valid <= 1'b1;
                        state     <= OUT;
                    end else if (timer == TLIM) begin
                        res_err   <= 1'b1;
                        res_valid <= 1'b1;
                        state     <= OUT;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                OUT: begin
                    if (bus.res_ready_i) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                        if (!res_err) job_count <= job_count + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready_o  = (state == IDLE);
    assign bus.acc_start_o = acc_start;
    assign bus.acc_data_o  = acc_data;
    assign bus.res_valid_o = res_valid;
    assign bus.res_data_o  = res_data;
    assign bus.res_err_o   = res_err;
    assign busy_o          = (state != IDLE);
    assign job_count_o     = job_count;
endmodule

// File: tb/tb_accel_host_driver.sv
// tb/tb_accel_host_driver.sv - self-checking bench against a byte-sum accelerator model
module tb_accel_host_driver;
    localparam int T = 16;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        busy;
    logic [15:0] job_count;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          exp_count = 0;

    // accelerator behaviour: 0 compliant, 1 done stuck low, 2 done stuck high after completion
    int          acc_mode = 0;
    int          acc_st = 0;
    logic        done_r = 1'b0;
    logic [31:0] acc_out = '0;
    logic [31:0] acc_in_word = '0;

    accel_host_driver_if #(.DATA_W(32)) bus ();

    accel_host_driver #(.DATA_W(32), .TIMEOUT_CYCLES(T), .CNT_W(16)) dut (
        .clk_i      (clk),
        .arst_n_i   (arst_n),
        .bus        (bus.master),
        .busy_o     (busy),
        .job_count_o(job_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] byte_sum(input logic [31:0] w);
        return 32'(w[7:0]) + 32'(w[15:8]) + 32'(w[23:16]) + 32'(w[31:24]);
    endfunction

    always @(posedge clk) begin
        case (acc_st)
            0: if (bus.acc_start_o) begin acc_in_word <= bus.acc_data_o; acc_st <= 1; end
            1: begin done_r <= 1'b1; acc_out <= byte_sum(acc_in_word); acc_st <= 2; end
            2: if (!bus.acc_start_o && acc_mode != 2) acc_st <= 3;
            default: begin done_r <= 1'b0; acc_st <= 0; end
        endcase
    end

    assign bus.acc_done_i = (acc_mode == 1) ? 1'b0 : done_r;
    assign bus.acc_data_i = acc_out;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // caller is positioned just after a falling edge
    task automatic run_job(input logic [31:0] word, input int mode, input int hold, input bit keep);
        logic [31:0] exp_d;
        logic        exp_e;
        int          exp_fall, exp_rise, e, fall_e, rise_e;
        exp_e    = (mode != 0);
        exp_d    = (mode == 1) ? 32'h0 : byte_sum(word);
        exp_fall = (mode == 1) ? T : 3;
        exp_rise = (mode == 0) ? 6 : (mode == 1) ? T + 1 : 3 + T;
        acc_mode = mode;
        bus.in_valid_i  = 1'b1;
        bus.in_data_i   = word;
        bus.res_ready_i = keep;
        chk("in_ready_idle", 32'(bus.in_ready_o), 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("start_high", 32'(bus.acc_start_o), 32'd1);
        chk("acc_data", bus.acc_data_o, word);
        chk("in_ready_busy", 32'(bus.in_ready_o), 32'd0);
        bus.in_valid_i = keep;
        if (!keep) bus.in_data_i = $urandom;
        e = 0; fall_e = -1; rise_e = -1;
        while (rise_e < 0 && e < 200) begin
            @(posedge clk);
            e++;
            @(negedge clk);
            if (fall_e < 0 && !bus.acc_start_o) fall_e = e;
            if (bus.res_valid_o) rise_e = e;
        end
        chk("start_fall_edge", 32'(fall_e), 32'(exp_fall));
        chk("valid_rise_edge", 32'(rise_e), 32'(exp_rise));
        chk("res_data", bus.res_data_o, exp_d);
        chk("res_err", 32'(bus.res_err_o), 32'(exp_e));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("hold_valid", 32'(bus.res_valid_o), 32'd1);
            chk("hold_data", bus.res_data_o, exp_d);
            chk("hold_in_ready", 32'(bus.in_ready_o), 32'd0);
        end
        bus.res_ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.res_ready_i = keep;
        if (!exp_e) exp_count++;
        chk("valid_drop", 32'(bus.res_valid_o), 32'd0);
        chk("job_count", 32'(job_count), 32'(exp_count & 32'hFFFF));
        acc_mode = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] w;
        int          seen;
        arst_n = 1'b0;
        bus.in_valid_i  = 1'b0;
        bus.in_data_i   = '0;
        bus.res_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready_o), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_start", 32'(bus.acc_start_o), 32'd0);
        chk("rst_acc_data", bus.acc_data_o, 32'd0);
        chk("rst_res_valid", 32'(bus.res_valid_o), 32'd0);
        chk("rst_res_data", bus.res_data_o, 32'd0);
        chk("rst_res_err", 32'(bus.res_err_o), 32'd0);
        chk("rst_count", 32'(job_count), 32'd0);
        arst_n = 1'b1;
        @(negedge clk);

        run_job(32'h01020304, 0, 0, 1'b0);
        chk("sum_0a", bus.res_data_o, 32'h0000000A);
        run_job(32'hFFFFFFFF, 0, 5, 1'b0);
        run_job(32'h12345678, 1, 0, 1'b0);
        run_job(32'h10203040, 2, 1, 1'b0);
        chk("stale_done_seen", 32'(bus.acc_done_i), 32'd1);
        chk("stale_done_idle", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);

        run_job(32'h00000001, 0, 0, 1'b1);
        run_job(32'h01010101, 0, 0, 1'b1);
        run_job(32'h80808080, 0, 0, 1'b1);
        chk("b2b_last", bus.res_data_o, 32'h00000200);
        bus.in_valid_i  = 1'b0;
        bus.res_ready_i = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 8; k++) begin
            w = $urandom;
            run_job(w, 0, int'($urandom_range(0, 3)), 1'b0);
        end

        bus.in_valid_i = 1'b1;
        bus.in_data_i  = 32'hCAFEF00D;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("pre_rst_start", 32'(bus.acc_start_o), 32'd1);
        #2 arst_n = 1'b0;
        #1;
        chk("rst_mid_start", 32'(bus.acc_start_o), 32'd0);
        chk("rst_mid_in_ready", 32'(bus.in_ready_o), 32'd1);
        chk("rst_mid_count", 32'(job_count), 32'd0);
        exp_count = 0;
        @(posedge clk);
        @(negedge clk);
        arst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.res_valid_o) seen++;
        end
        chk("rst_no_result", 32'(seen), 32'd0);
        chk("rst_after_in_ready", 32'(bus.in_ready_o), 32'd1);
        chk("rst_after_count", 32'(job_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
